spi_controller: RTL and testbench

- SPI mode-0 controller (initiator): drives spi_clk, spi_cs and spi_copi, and samples spi_cipo.
- It is the opposite end of the SPI link served by our `bus` peripheral. It is used in benches and on-chip to issue byte frames to `bus`.
- A simple valid/ready byte interface on the system side. Full-duplex: every transmitted word returns one received word.

---
 rtl/spi_controller_if.sv | 36 +++
 rtl/spi_controller.sv | 160 ++++++++++++++++
 tb/tb_spi_controller.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_controller_if.sv
// System-side word interface of the SPI initiator.
// The client drives words in; the controller returns received words.
interface spi_controller_if #(
    parameter int unsigned DATA_WIDTH = 8
) ();
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic                  hold_cs;
    logic                  end_xfer;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  busy;

    modport master (
        output tx_data,
        output tx_valid,
        output hold_cs,
        output end_xfer,
        input  tx_ready,
        input  rx_data,
        input  rx_valid,
        input  busy
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        input  hold_cs,
        input  end_xfer,
        output tx_ready,
        output rx_data,
        output rx_valid,
        output busy
    );
endinterface

// File: rtl/spi_controller.sv
// SPI mode-0 initiator: MSB-first words out on COPI, full-duplex capture on CIPO.
// Valid/ready word interface, optional chip-select hold between words.
module spi_controller #(
    parameter int unsigned CLK_DIV    = 2,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    spi_controller_if.slave sys,
    output logic            spi_clk,
    output logic            spi_cs,
    output logic            spi_copi,
    input  logic            spi_cipo
);
    localparam int unsigned BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        HIGH,
        LOW,
        HOLD,
        GAP
    } state_e;

    state_e                state_q;
    logic [7:0]            phase_q;
    logic [BW-1:0]         bit_q;
    logic [DATA_WIDTH-1:0] tx_sh_q;
    logic [DATA_WIDTH-1:0] rx_sh_q;
    logic [DATA_WIDTH-1:0] rx_data_q;
    logic                  hold_q;
    logic                  sclk_q;
    logic                  cs_q;
    logic                  copi_q;
    logic                  ready_q;
    logic                  rx_valid_q;
    logic                  busy_q;

    logic                  phase_end;
    logic                  last_bit;
    logic                  accept;
    logic [DATA_WIDTH-1:0] tx_sh_d;
    logic [DATA_WIDTH-1:0] rx_sh_d;

    assign phase_end = (phase_q == DIV_LAST);
    assign last_bit  = (bit_q == BIT_LAST);
    assign accept    = sys.tx_valid && ((state_q == IDLE) || (state_q == HOLD));
    assign tx_sh_d   = tx_sh_q << 1;
    // CIPO enters at the LSB so the first bit ends up as the MSB
    assign rx_sh_d   = (rx_sh_q << 1) | DATA_WIDTH'(spi_cipo);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            phase_q    <= '0;
            bit_q      <= '0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            hold_q     <= 1'b0;
            sclk_q     <= 1'b0;
            cs_q       <= 1'b1;
            copi_q     <= 1'b0;
            ready_q    <= 1'b1;
            rx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            if (accept) begin
                // acceptance wins over end_xfer while holding CS
                state_q <= SETUP;
                phase_q <= '0;
                bit_q   <= '0;
                tx_sh_q <= sys.tx_data;
                hold_q  <= sys.hold_cs;
                cs_q    <= 1'b0;
                copi_q  <= sys.tx_data[DATA_WIDTH-1];
                ready_q <= 1'b0;
                busy_q  <= 1'b1;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        phase_q <= '0;
                    end
                    SETUP: begin
                        phase_q <= phase_end ? 8'd0 : phase_q + 8'd1;
                        if (phase_end) begin
                            state_q <= HIGH;
                            sclk_q  <= 1'b1;
                            rx_sh_q <= rx_sh_d;
                        end
                    end
                    HIGH: begin
                        phase_q <= phase_end ? 8'd0 : phase_q + 8'd1;
                        if (phase_end) begin
                            state_q <= LOW;
                            sclk_q  <= 1'b0;
                            if (!last_bit) begin
                                tx_sh_q <= tx_sh_d;
                                copi_q  <= tx_sh_d[DATA_WIDTH-1];
                            end
                        end
                    end
                    LOW: begin
                        phase_q <= phase_end ? 8'd0 : phase_q + 8'd1;
                        if (phase_end && !last_bit) begin
                            bit_q   <= bit_q + BW'(1);
                            state_q <= HIGH;
                            sclk_q  <= 1'b1;
                            rx_sh_q <= rx_sh_d;
                        end else if (phase_end) begin
                            rx_data_q  <= rx_sh_q;
                            rx_valid_q <= 1'b1;
                            copi_q     <= 1'b0;
                            bit_q      <= '0;
                            if (hold_q) begin
                                state_q <= HOLD;
                                ready_q <= 1'b1;
                            end else begin
                                state_q <= GAP;
                                cs_q    <= 1'b1;
                            end
                        end
                    end
                    HOLD: begin
                        phase_q <= '0;
                        if (sys.end_xfer) begin
                            state_q <= GAP;
                            cs_q    <= 1'b1;
                            ready_q <= 1'b0;
                        end
                    end
                    GAP: begin
                        // keeps CS high for a full half-period before the next frame
                        phase_q <= phase_end ? 8'd0 : phase_q + 8'd1;
                        if (phase_end) begin
                            state_q <= IDLE;
                            ready_q <= 1'b1;
                            busy_q  <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign sys.tx_ready = ready_q;
    assign sys.rx_data  = rx_data_q;
    assign sys.rx_valid = rx_valid_q;
    assign sys.busy     = busy_q;
    assign spi_clk      = sclk_q;
    assign spi_cs       = cs_q;
    assign spi_copi     = copi_q;
endmodule

// File: tb/tb_spi_controller.sv
// Directed bench for spi_controller: one DUT at CLK_DIV=2, one at CLK_DIV=1.
// A posedge monitor counts CS-low cycles, SCLK rises, COPI bits and rx words.
module tb_spi_controller;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       sel = 1'b0;
    logic       loop = 1'b1;
    logic       cipo_fix = 1'b0;
    logic       tx_valid = 1'b0;
    logic       hold_cs = 1'b0;
    logic       end_xfer = 1'b0;
    logic [7:0] tx_data = 8'h00;

    spi_controller_if #(.DATA_WIDTH(8)) ifa ();
    spi_controller_if #(.DATA_WIDTH(8)) ifb ();

    logic sclk_a, cs_a, copi_a, cipo_a;
    logic sclk_b, cs_b, copi_b, cipo_b;

    assign ifa.tx_data  = tx_data;
    assign ifa.hold_cs  = hold_cs;
    assign ifa.tx_valid = tx_valid & ~sel;
    assign ifa.end_xfer = end_xfer & ~sel;
    assign ifb.tx_data  = tx_data;
    assign ifb.hold_cs  = hold_cs;
    assign ifb.tx_valid = tx_valid & sel;
    assign ifb.end_xfer = end_xfer & sel;
    assign cipo_a = loop ? copi_a : cipo_fix;
    assign cipo_b = loop ? copi_b : cipo_fix;

    spi_controller #(.CLK_DIV(2), .DATA_WIDTH(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .sys(ifa),
        .spi_clk(sclk_a), .spi_cs(cs_a),
        .spi_copi(copi_a), .spi_cipo(cipo_a)
    );

    spi_controller #(.CLK_DIV(1), .DATA_WIDTH(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .sys(ifb),
        .spi_clk(sclk_b), .spi_cs(cs_b),
        .spi_copi(copi_b), .spi_cipo(cipo_b)
    );

    logic       obs_cs, obs_sclk, obs_copi, obs_ready, obs_rxv, obs_busy;
    logic [7:0] obs_rxd;
    assign obs_cs    = sel ? cs_b : cs_a;
    assign obs_sclk  = sel ? sclk_b : sclk_a;
    assign obs_copi  = sel ? copi_b : copi_a;
    assign obs_ready = sel ? ifb.tx_ready : ifa.tx_ready;
    assign obs_rxv   = sel ? ifb.rx_valid : ifa.rx_valid;
    assign obs_busy  = sel ? ifb.busy : ifa.busy;
    assign obs_rxd   = sel ? ifb.rx_data : ifa.rx_data;

    int         n_checks = 0;
    int         n_fail = 0;
    int         to_err = 0;
    int         cs_low_cnt = 0;
    int         edges = 0;
    int         rxv_cnt = 0;
    int         cs_rise_cnt = 0;
    logic [7:0] copi_bits = 8'h00;
    logic [7:0] rxq[$];
    logic       prev_sclk = 1'b0;
    logic       prev_cs = 1'b1;

    always @(posedge clk) begin
        #1;
        if (!obs_cs) cs_low_cnt++;
        if (obs_sclk && !prev_sclk) begin
            edges++;
            copi_bits = {copi_bits[6:0], obs_copi};
        end
        if (obs_cs && !prev_cs) cs_rise_cnt++;
        if (obs_rxv) begin
            rxv_cnt++;
            rxq.push_back(obs_rxd);
        end
        prev_sclk = obs_sclk;
        prev_cs = obs_cs;
    end

    task automatic clr();
        cs_low_cnt = 0;
        edges = 0;
        rxv_cnt = 0;
        cs_rise_cnt = 0;
        copi_bits = 8'h00;
        rxq.delete();
        prev_sclk = obs_sclk;
        prev_cs = obs_cs;
        to_err = 0;
    endtask

    task automatic send(input logic [7:0] d, input logic h);
        int k = 0;
        while (obs_ready !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) to_err++;
        tx_data = d;
        hold_cs = h;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_rx(input int n);
        int k = 0;
        while (rxv_cnt < n && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (rxv_cnt < n) to_err++;
    endtask

    task automatic wait_rise(input int n);
        int k = 0;
        while (cs_rise_cnt < n && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (cs_rise_cnt < n) to_err++;
    endtask

    task automatic wait_ready(output int k);
        k = 0;
        while (obs_ready !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if (obs_sclk !== 1'b0) begin n_fail++; $display("FAIL reset_sclk: got %b want 0", obs_sclk); end
        n_checks++;
        if (obs_cs !== 1'b1) begin n_fail++; $display("FAIL reset_cs: got %b want 1", obs_cs); end
        n_checks++;
        if (obs_copi !== 1'b0) begin n_fail++; $display("FAIL reset_copi: got %b want 0", obs_copi); end
        n_checks++;
        if (obs_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", obs_ready); end
        n_checks++;
        if (obs_rxv !== 1'b0) begin n_fail++; $display("FAIL reset_rxv: got %b want 0", obs_rxv); end
        n_checks++;
        if (obs_rxd !== 8'h00) begin n_fail++; $display("FAIL reset_rxd: got %h want 00", obs_rxd); end
        n_checks++;
        if (obs_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", obs_busy); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_loopback();
        int k;
        sel = 1'b0;
        loop = 1'b1;
        clr();
        send(8'hA5, 1'b0);
        wait_rise(1);
        wait_ready(k);
        n_checks++;
        if (to_err !== 0) begin n_fail++; $display("FAIL lb_timeout: got %0d want 0", to_err); end
        n_checks++;
        if (cs_low_cnt !== 34) begin n_fail++; $display("FAIL lb_cs_low: got %0d want 34", cs_low_cnt); end
        n_checks++;
        if (edges !== 8) begin n_fail++; $display("FAIL lb_edges: got %0d want 8", edges); end
        n_checks++;
        if (copi_bits !== 8'hA5) begin n_fail++; $display("FAIL lb_copi: got %h want a5", copi_bits); end
        n_checks++;
        if (rxv_cnt !== 1) begin n_fail++; $display("FAIL lb_rxv_cnt: got %0d want 1", rxv_cnt); end
        n_checks++;
        if (rxq[0] !== 8'hA5) begin n_fail++; $display("FAIL lb_rxd: got %h want a5", rxq[0]); end
        n_checks++;
        if (k !== 2) begin n_fail++; $display("FAIL lb_gap: got %0d want 2", k); end
        n_checks++;
        if (obs_busy !== 1'b0) begin n_fail++; $display("FAIL lb_busy: got %b want 0", obs_busy); end
    endtask

    task automatic test_fixed_cipo();
        sel = 1'b0;
        loop = 1'b0;
        cipo_fix = 1'b1;
        clr();
        send(8'h00, 1'b0);
        wait_rise(1);
        n_checks++;
        if (rxq[0] !== 8'hFF) begin n_fail++; $display("FAIL cipo1_rxd: got %h want ff", rxq[0]); end
        n_checks++;
        if (copi_bits !== 8'h00) begin n_fail++; $display("FAIL cipo1_copi: got %h want 00", copi_bits); end
        clr();
        cipo_fix = 1'b0;
        send(8'hFF, 1'b0);
        wait_rise(1);
        n_checks++;
        if (rxq[0] !== 8'h00) begin n_fail++; $display("FAIL cipo0_rxd: got %h want 00", rxq[0]); end
        n_checks++;
        if (copi_bits !== 8'hFF) begin n_fail++; $display("FAIL cipo0_copi: got %h want ff", copi_bits); end
        n_checks++;
        if (to_err !== 0) begin n_fail++; $display("FAIL cipo_timeout: got %0d want 0", to_err); end
        loop = 1'b1;
    endtask

    task automatic test_back_to_back();
        sel = 1'b0;
        loop = 1'b1;
        send(8'h00, 1'b0);
        wait_rise(0);
        @(negedge clk);
        while (obs_ready !== 1'b1) @(negedge clk);
        clr();
        send(8'h12, 1'b1);
        wait_rx(1);
        n_checks++;
        if (cs_rise_cnt !== 0) begin n_fail++; $display("FAIL b2b_hold_cs: got %0d rises want 0", cs_rise_cnt); end
        send(8'h34, 1'b0);
        wait_rise(1);
        n_checks++;
        if (rxq.size() !== 2) begin n_fail++; $display("FAIL b2b_count: got %0d want 2", rxq.size()); end
        n_checks++;
        if (rxq[0] !== 8'h12 || rxq[1] !== 8'h34) begin
            n_fail++;
            $display("FAIL b2b_rxd: got %h %h want 12 34", rxq[0], rxq[1]);
        end
        n_checks++;
        if (cs_low_cnt !== 69) begin n_fail++; $display("FAIL b2b_cs_low: got %0d want 69", cs_low_cnt); end
        n_checks++;
        if (edges !== 16) begin n_fail++; $display("FAIL b2b_edges: got %0d want 16", edges); end
        n_checks++;
        if (to_err !== 0) begin n_fail++; $display("FAIL b2b_timeout: got %0d want 0", to_err); end
    endtask

    task automatic test_hold_end();
        int k;
        sel = 1'b0;
        loop = 1'b1;
        clr();
        send(8'h5A, 1'b1);
        wait_rx(1);
        tx_data = 8'hC3;
        hold_cs = 1'b1;
        tx_valid = 1'b1;
        end_xfer = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        end_xfer = 1'b0;
        n_checks++;
        if (obs_cs !== 1'b0 || obs_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL tie_start: got cs=%b ready=%b want 0 0", obs_cs, obs_ready);
        end
        wait_rx(2);
        n_checks++;
        if (rxq[1] !== 8'hC3) begin n_fail++; $display("FAIL tie_rxd: got %h want c3", rxq[1]); end
        n_checks++;
        if (obs_cs !== 1'b0 || obs_ready !== 1'b1 || cs_rise_cnt !== 0) begin
            n_fail++;
            $display("FAIL hold_state: got cs=%b ready=%b rises=%0d want 0 1 0", obs_cs, obs_ready, cs_rise_cnt);
        end
        end_xfer = 1'b1;
        @(negedge clk);
        end_xfer = 1'b0;
        n_checks++;
        if (obs_cs !== 1'b1 || obs_ready !== 1'b0 || obs_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL end_xfer: got cs=%b ready=%b busy=%b want 1 0 1", obs_cs, obs_ready, obs_busy);
        end
        wait_ready(k);
        n_checks++;
        if (k !== 2) begin n_fail++; $display("FAIL end_gap: got %0d want 2", k); end
        n_checks++;
        if (to_err !== 0) begin n_fail++; $display("FAIL hold_timeout: got %0d want 0", to_err); end
    endtask

    task automatic test_reset_mid();
        int k = 0;
        sel = 1'b0;
        loop = 1'b1;
        clr();
        send(8'h81, 1'b0);
        while (edges < 3 && k < 100) begin
            @(negedge clk);
            k++;
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (obs_cs !== 1'b1 || obs_sclk !== 1'b0 || obs_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_out: got cs=%b sclk=%b ready=%b want 1 0 1", obs_cs, obs_sclk, obs_ready);
        end
        n_checks++;
        if (obs_rxv !== 1'b0 || obs_copi !== 1'b0 || obs_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_misc: got rxv=%b copi=%b busy=%b want 0 0 0", obs_rxv, obs_copi, obs_busy);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (rxv_cnt !== 0) begin n_fail++; $display("FAIL rstmid_rxv: got %0d want 0", rxv_cnt); end
        clr();
        send(8'h3C, 1'b0);
        wait_rise(1);
        n_checks++;
        if (rxv_cnt !== 1 || rxq[0] !== 8'h3C) begin
            n_fail++;
            $display("FAIL rstmid_fresh: got cnt=%0d rxd=%h want 1 3c", rxv_cnt, rxq[0]);
        end
        n_checks++;
        if (cs_low_cnt !== 34 || edges !== 8) begin
            n_fail++;
            $display("FAIL rstmid_frame: got low=%0d edges=%0d want 34 8", cs_low_cnt, edges);
        end
    endtask

    task automatic test_ignore();
        sel = 1'b0;
        loop = 1'b1;
        clr();
        send(8'h96, 1'b0);
        repeat (6) @(negedge clk);
        tx_data = 8'hFF;
        hold_cs = 1'b1;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (10) @(negedge clk);
        tx_valid = 1'b1;
        end_xfer = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        end_xfer = 1'b0;
        wait_rise(1);
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (40) @(negedge clk);
        n_checks++;
        if (rxv_cnt !== 1 || rxq[0] !== 8'h96) begin
            n_fail++;
            $display("FAIL ign_rx: got cnt=%0d rxd=%h want 1 96", rxv_cnt, rxq[0]);
        end
        n_checks++;
        if (cs_low_cnt !== 34 || cs_rise_cnt !== 1) begin
            n_fail++;
            $display("FAIL ign_frame: got low=%0d rises=%0d want 34 1", cs_low_cnt, cs_rise_cnt);
        end
        n_checks++;
        if (obs_busy !== 1'b0 || obs_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ign_idle: got busy=%b ready=%b want 0 1", obs_busy, obs_ready);
        end
        n_checks++;
        if (to_err !== 0) begin n_fail++; $display("FAIL ign_timeout: got %0d want 0", to_err); end
    endtask

    task automatic test_div1();
        int k;
        sel = 1'b1;
        loop = 1'b1;
        @(negedge clk);
        clr();
        send(8'hA5, 1'b0);
        wait_rise(1);
        wait_ready(k);
        n_checks++;
        if (cs_low_cnt !== 17) begin n_fail++; $display("FAIL div1_cs_low: got %0d want 17", cs_low_cnt); end
        n_checks++;
        if (rxq[0] !== 8'hA5 || edges !== 8) begin
            n_fail++;
            $display("FAIL div1_word: got rxd=%h edges=%0d want a5 8", rxq[0], edges);
        end
        n_checks++;
        if (k !== 1) begin n_fail++; $display("FAIL div1_gap: got %0d want 1", k); end
        n_checks++;
        if (to_err !== 0) begin n_fail++; $display("FAIL div1_timeout: got %0d want 0", to_err); end
        sel = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_loopback();
        test_fixed_cipo();
        test_back_to_back();
        test_hold_end();
        test_reset_mid();
        test_ignore();
        test_div1();
        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
